multicycle_controller: RTL and testbench
========================================

# multicycle_controller

Main control FSM for the multi-cycle MIPS core variant. Sequences one shared ALU, one unified instruction/data memory port and the register file across FETCH/DECODE/EXECUTE/MEMORY/WRITEBACK states. Emits the 4-bit `alu_op` consumed by `alu_controller`, plus all datapath mux selects and write enables. Also counts retired instructions.

## Interface
- No parameters.
- `clk` in 1: single clock, rising edge.
- `rst_n` in 1: asynchronous, active-low reset.
- `opcode` in 6: IR[31:26], taken from the datapath instruction register.
- `funct` in 6: IR[5:0].
- `zero` in 1: ALU zero flag.
- `mem_ready` in 1: memory completes the current request this cycle.
- `mem_req` out 1: memory request, held until `mem_ready`.
- `mem_we` out 1: write request (store).
- `iord` out 1: address source, 0 = PC, 1 = ALUOut.
- `ir_write` out 1: load IR.
- `pc_write` out 1: load PC.
- `pc_src` out 2: 00 = ALU result, 01 = ALUOut, 10 = jump target.
- `reg_write` out 1: register file write enable.
- `reg_dst` out 1: 1 = rd, 0 = rt.
- `mem_to_reg` out 1: 1 = MDR, 0 = ALUOut.
- `alu_src_a` out 1: 0 = PC, 1 = A.
- `alu_src_b` out 2: 00 = B, 01 = constant 4, 10 = extended immediate, 11 = extended immediate << 2.
- `ext_zero` out 1: immediate zero-extension (andi/ori/xori).
- `alu_op` out 4: ADD 0000, SUB 0001, AND 0010, OR 0011, XOR 0100, NOR 0101, SLT 0110, SLTU 0111, LUI 1000.
- `illegal` out 1: sticky trap flag.
- `retired` out 32: retired-instruction count.

## Operation
- States: IDLE, FETCH, DECODE, MEM_ADDR, MEM_READ, MEM_WB, MEM_WRITE, R_EXEC, R_WB, I_EXEC, I_WB, BRANCH, JUMP, TRAP.
- Outputs are a combinational function of state, `opcode`/`funct`, `zero` and `mem_ready`. Every output not listed for a state is 0.
- **IDLE**: reset state, all outputs 0. Goes to FETCH unconditionally.
- **FETCH**:
  - Asserts `mem_req`, `iord`=0, `alu_src_a`=0, `alu_src_b`=01, `alu_op`=ADD, `pc_src`=00.
  - `ir_write` = `pc_write` = `mem_ready`.
  - Stays in FETCH until `mem_ready`, then goes to DECODE.
- **DECODE**: `alu_src_a`=0, `alu_src_b`=11, ADD (branch target into ALUOut). Next state by opcode:
  - lw 0x23, sw 0x2B → MEM_ADDR.
  - opcode 0x00 with legal funct → R_EXEC.
  - addi 08, addiu 09, slti 0A, sltiu 0B, andi 0C, ori 0D, xori 0E, lui 0F → I_EXEC.
  - beq 04, bne 05 → BRANCH.
  - j 02 → JUMP.
  - Anything else → TRAP.
- **Legal R-type funct**: 20/21 ADD, 22/23 SUB, 24 AND, 25 OR, 26 XOR, 27 NOR, 2A SLT, 2B SLTU.
- **MEM_ADDR**: `alu_src_a`=1, `alu_src_b`=10, ADD. Goes to MEM_READ (lw) or MEM_WRITE (sw).
- **MEM_READ**: `mem_req`, `iord`=1. Waits for `mem_ready`, then goes to MEM_WB.
- **MEM_WB**: `reg_write`, `mem_to_reg`=1, `reg_dst`=0. Retires, goes to FETCH.
- **MEM_WRITE**: `mem_req`, `mem_we`, `iord`=1. On `mem_ready`, retires and goes to FETCH.
- **R_EXEC**: `alu_src_a`=1, `alu_src_b`=00, `alu_op` from funct. Goes to R_WB.
- **R_WB**: `reg_write`, `reg_dst`=1. Retires, goes to FETCH.
- **I_EXEC**: `alu_src_a`=1, `alu_src_b`=10, `alu_op` from opcode, `ext_zero` for 0C/0D/0E. Goes to I_WB.
- **I_WB**: `reg_write`, `reg_dst`=0. Retires, goes to FETCH.
- **BRANCH**: `alu_src_a`=1, `alu_src_b`=00, SUB, `pc_src`=01.
  - `pc_write` = `zero` for beq, `!zero` for bne.
  - Retires, goes to FETCH.
- **JUMP**: `pc_src`=10, `pc_write`. Retires, goes to FETCH.
- **TRAP**: `illegal`=1 and all other outputs 0. Absorbing; only `rst_n` exits. `retired` is not incremented.
- **`retired`**: 32-bit register, +1 on each retiring transition, wraps 0xFFFFFFFF → 0.

## Timing
- Reset values: state IDLE, `retired`=0, all outputs 0. Reset applies asynchronously at any time, including mid-handshake; the memory request is dropped immediately.
- Latency with zero-wait memory (`mem_ready` high during the request cycle), excluding IDLE:
  - j, beq, bne: 3 cycles.
  - R-type, I-type, sw: 4 cycles.
  - lw: 5 cycles.
- Each memory wait cycle adds one cycle.
- `mem_req`/`mem_we`/`iord` are stable while waiting. `pc_write`/`ir_write` never assert without `mem_ready` in FETCH.
- `retired` updates on the clock edge that leaves the final state of the instruction.

## Structure
- Shared package `mips_ctrl_pkg`: state enum, opcode/funct constants, `alu_op` codes, `alu_src_b`/`pc_src` encodings. `alu_controller` imports the same `alu_op` codes.
- One sub-module: `mc_alu_op_decode`, combinational opcode/funct → `alu_op` plus legal flag. Used by both R_EXEC/I_EXEC and DECODE legality.

## Test plan
- **Reset then add** (opcode 00, funct 20, `mem_ready`=1): IDLE→FETCH→DECODE→R_EXEC→R_WB→FETCH. `alu_op`=0000 in R_EXEC, `reg_write`=`reg_dst`=1 in R_WB, `retired`=1.
- **lw with 2 memory wait cycles in both FETCH and MEM_READ**: 9 cycles from FETCH entry. `mem_req` held steady, single `ir_write` pulse, `mem_to_reg`=1 in MEM_WB.
- **beq with `zero`=1, then bne with `zero`=1**: `pc_write`=1 with `pc_src`=01 for beq, `pc_write`=0 for bne. Both retire.
- **ori (0x0D), then lui (0x0F)**: `ext_zero`=1 and `alu_op`=0011 for ori; `ext_zero`=0 and `alu_op`=1000 for lui.
- **Illegal opcode 0x3F, and R-type with funct 0x00**: TRAP, `illegal`=1 held for 10+ cycles, `retired` unchanged. `rst_n` pulse returns to IDLE.
- **Counter wrap and mid-fetch reset**: preload `retired`=0xFFFFFFFF (force), then a j → 0. Asserting `rst_n`=0 mid-FETCH with `mem_ready`=0 drives `mem_req` to 0 asynchronously.

Source files
------------

// File: rtl/mips_ctrl_pkg.sv
// Shared encodings for the multi-cycle MIPS control path: FSM states, opcode/funct
// constants, ALU operation codes and datapath mux select encodings.
package mips_ctrl_pkg;

    typedef enum logic [3:0] {
        S_IDLE      = 4'd0,
        S_FETCH     = 4'd1,
        S_DECODE    = 4'd2,
        S_MEM_ADDR  = 4'd3,
        S_MEM_READ  = 4'd4,
        S_MEM_WB    = 4'd5,
        S_MEM_WRITE = 4'd6,
        S_R_EXEC    = 4'd7,
        S_R_WB      = 4'd8,
        S_I_EXEC    = 4'd9,
        S_I_WB      = 4'd10,
        S_BRANCH    = 4'd11,
        S_JUMP      = 4'd12,
        S_TRAP      = 4'd13
    } state_t;

    // Shared with alu_controller; keep the encodings in lockstep.
    typedef enum logic [3:0] {
        ALU_ADD  = 4'b0000,
        ALU_SUB  = 4'b0001,
        ALU_AND  = 4'b0010,
        ALU_OR   = 4'b0011,
        ALU_XOR  = 4'b0100,
        ALU_NOR  = 4'b0101,
        ALU_SLT  = 4'b0110,
        ALU_SLTU = 4'b0111,
        ALU_LUI  = 4'b1000
    } alu_op_t;

    localparam logic [5:0] OP_RTYPE = 6'h00;
    localparam logic [5:0] OP_J     = 6'h02;
    localparam logic [5:0] OP_BEQ   = 6'h04;
    localparam logic [5:0] OP_BNE   = 6'h05;
    localparam logic [5:0] OP_ADDI  = 6'h08;
    localparam logic [5:0] OP_ADDIU = 6'h09;
    localparam logic [5:0] OP_SLTI  = 6'h0A;
    localparam logic [5:0] OP_SLTIU = 6'h0B;
    localparam logic [5:0] OP_ANDI  = 6'h0C;
    localparam logic [5:0] OP_ORI   = 6'h0D;
    localparam logic [5:0] OP_XORI  = 6'h0E;
    localparam logic [5:0] OP_LUI   = 6'h0F;
    localparam logic [5:0] OP_LW    = 6'h23;
    localparam logic [5:0] OP_SW    = 6'h2B;

    localparam logic [5:0] FN_ADD  = 6'h20;
    localparam logic [5:0] FN_ADDU = 6'h21;
    localparam logic [5:0] FN_SUB  = 6'h22;
    localparam logic [5:0] FN_SUBU = 6'h23;
    localparam logic [5:0] FN_AND  = 6'h24;
    localparam logic [5:0] FN_OR   = 6'h25;
    localparam logic [5:0] FN_XOR  = 6'h26;
    localparam logic [5:0] FN_NOR  = 6'h27;
    localparam logic [5:0] FN_SLT  = 6'h2A;
    localparam logic [5:0] FN_SLTU = 6'h2B;

    localparam logic [1:0] SRC_B_REG     = 2'b00;
    localparam logic [1:0] SRC_B_FOUR    = 2'b01;
    localparam logic [1:0] SRC_B_IMM     = 2'b10;
    localparam logic [1:0] SRC_B_IMM_SH2 = 2'b11;

    localparam logic [1:0] PC_SRC_ALU    = 2'b00;
    localparam logic [1:0] PC_SRC_ALUOUT = 2'b01;
    localparam logic [1:0] PC_SRC_JUMP   = 2'b10;

    // Logical immediates are zero-extended; arithmetic ones are sign-extended.
    function automatic logic is_zero_ext(input logic [5:0] op);
        return (op == OP_ANDI) || (op == OP_ORI) || (op == OP_XORI);
    endfunction

endpackage

// File: rtl/multicycle_controller_if.sv
// Control/datapath bundle between the multi-cycle controller (master) and the
// datapath plus unified memory port (slave).
interface multicycle_controller_if;
    logic [5:0]  opcode;
    logic [5:0]  funct;
    logic        zero;
    logic        mem_ready;
    logic        mem_req;
    logic        mem_we;
    logic        iord;
    logic        ir_write;
    logic        pc_write;
    logic [1:0]  pc_src;
    logic        reg_write;
    logic        reg_dst;
    logic        mem_to_reg;
    logic        alu_src_a;
    logic [1:0]  alu_src_b;
    logic        ext_zero;
    logic [3:0]  alu_op;
    logic        illegal;
    logic [31:0] retired;

    modport master (
        input  opcode, funct, zero, mem_ready,
        output mem_req, mem_we, iord, ir_write, pc_write, pc_src,
               reg_write, reg_dst, mem_to_reg, alu_src_a, alu_src_b,
               ext_zero, alu_op, illegal, retired
    );

    modport slave (
        output opcode, funct, zero, mem_ready,
        input  mem_req, mem_we, iord, ir_write, pc_write, pc_src,
               reg_write, reg_dst, mem_to_reg, alu_src_a, alu_src_b,
               ext_zero, alu_op, illegal, retired
    );
endinterface

// File: rtl/mc_alu_op_decode.sv
// Maps opcode/funct to an ALU operation and flags whether the instruction is a
// legal register- or immediate-form ALU instruction.
module mc_alu_op_decode
    import mips_ctrl_pkg::*;
(
    input  logic [5:0] opcode,
    input  logic [5:0] funct,
    output alu_op_t    alu_op,
    output logic       legal
);

    always_comb begin
        alu_op = ALU_ADD;
        legal  = 1'b1;
        if (opcode == OP_RTYPE) begin
            case (funct)
                FN_ADD, FN_ADDU: alu_op = ALU_ADD;
                FN_SUB, FN_SUBU: alu_op = ALU_SUB;
                FN_AND:          alu_op = ALU_AND;
                FN_OR:           alu_op = ALU_OR;
                FN_XOR:          alu_op = ALU_XOR;
                FN_NOR:          alu_op = ALU_NOR;
                FN_SLT:          alu_op = ALU_SLT;
                FN_SLTU:         alu_op = ALU_SLTU;
                default:         legal  = 1'b0;
            endcase
        end else begin
            case (opcode)
                OP_ADDI, OP_ADDIU: alu_op = ALU_ADD;
                OP_SLTI:           alu_op = ALU_SLT;
                OP_SLTIU:          alu_op = ALU_SLTU;
                OP_ANDI:           alu_op = ALU_AND;
                OP_ORI:            alu_op = ALU_OR;
                OP_XORI:           alu_op = ALU_XOR;
                OP_LUI:            alu_op = ALU_LUI;
                default:           legal  = 1'b0;
            endcase
        end
    end

endmodule

// File: rtl/multicycle_controller.sv
// Main control FSM of the multi-cycle MIPS core: sequences fetch, decode, execute,
// memory and writeback over a shared ALU and memory port; counts retired instructions.
//
// state     | meaning
// IDLE      | post-reset, all outputs low
// FETCH     | read instruction at PC, PC+4 into PC on mem_ready
// DECODE    | branch target into ALUOut, dispatch on opcode
// MEM_ADDR  | A + imm effective address
// MEM_READ  | load request, wait for mem_ready
// MEM_WB    | MDR into rt
// MEM_WRITE | store request, wait for mem_ready
// R_EXEC    | A op B
// R_WB      | ALUOut into rd
// I_EXEC    | A op imm
// I_WB      | ALUOut into rt
// BRANCH    | A - B, conditional PC load from ALUOut
// JUMP      | PC load from jump target
// TRAP      | illegal instruction, absorbing
module multicycle_controller
    import mips_ctrl_pkg::*;
(
    input  logic                   clk,
    input  logic                   rst_n,
    multicycle_controller_if.master bus
);

    state_t      state_q, state_d;
    logic [31:0] retired_q;
    logic        retire;
    alu_op_t     dec_alu_op;
    logic        dec_legal;

    logic        mem_req, mem_we, iord, ir_write, pc_write;
    logic [1:0]  pc_src, alu_src_b;
    logic        reg_write, reg_dst, mem_to_reg, alu_src_a, ext_zero, illegal;
    alu_op_t     alu_op;

    mc_alu_op_decode u_alu_op_decode (
        .opcode (bus.opcode),
        .funct  (bus.funct),
        .alu_op (dec_alu_op),
        .legal  (dec_legal)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            retired_q <= 32'd0;
        end else if (retire) begin
            retired_q <= retired_q + 32'd1;
        end
    end

    always_comb begin
        state_d    = state_q;
        retire     = 1'b0;
        mem_req    = 1'b0;
        mem_we     = 1'b0;
        iord       = 1'b0;
        ir_write   = 1'b0;
        pc_write   = 1'b0;
        pc_src     = PC_SRC_ALU;
        reg_write  = 1'b0;
        reg_dst    = 1'b0;
        mem_to_reg = 1'b0;
        alu_src_a  = 1'b0;
        alu_src_b  = SRC_B_REG;
        ext_zero   = 1'b0;
        alu_op     = ALU_ADD;
        illegal    = 1'b0;

        case (state_q)
            S_IDLE: state_d = S_FETCH;
            S_FETCH: begin
                mem_req   = 1'b1;
                alu_src_b = SRC_B_FOUR;
                ir_write  = bus.mem_ready;
                pc_write  = bus.mem_ready;
                if (bus.mem_ready) state_d = S_DECODE;
            end
            S_DECODE: begin
                alu_src_b = SRC_B_IMM_SH2;
                case (bus.opcode)
                    OP_LW, OP_SW:   state_d = S_MEM_ADDR;
                    OP_BEQ, OP_BNE: state_d = S_BRANCH;
                    OP_J:           state_d = S_JUMP;
                    default: begin
                        if (!dec_legal)                   state_d = S_TRAP;
                        else if (bus.opcode == OP_RTYPE)  state_d = S_R_EXEC;
                        else                              state_d = S_I_EXEC;
                    end
                endcase
            end
            S_MEM_ADDR: begin
                alu_src_a = 1'b1;
                alu_src_b = SRC_B_IMM;
                state_d   = (bus.opcode == OP_SW) ? S_MEM_WRITE : S_MEM_READ;
            end
            S_MEM_READ: begin
                mem_req = 1'b1;
                iord    = 1'b1;
                if (bus.mem_ready) state_d = S_MEM_WB;
            end
            S_MEM_WB: begin
                reg_write  = 1'b1;
                mem_to_reg = 1'b1;
                retire     = 1'b1;
                state_d    = S_FETCH;
            end
            S_MEM_WRITE: begin
                mem_req = 1'b1;
                mem_we  = 1'b1;
                iord    = 1'b1;
                if (bus.mem_ready) begin
                    retire  = 1'b1;
                    state_d = S_FETCH;
                end
            end
            S_R_EXEC: begin
                alu_src_a = 1'b1;
                alu_op    = dec_alu_op;
                state_d   = S_R_WB;
            end
            S_R_WB: begin
                reg_write = 1'b1;
                reg_dst   = 1'b1;
                retire    = 1'b1;
                state_d   = S_FETCH;
            end
            S_I_EXEC: begin
                alu_src_a = 1'b1;
                alu_src_b = SRC_B_IMM;
                alu_op    = dec_alu_op;
                ext_zero  = is_zero_ext(bus.opcode);
                state_d   = S_I_WB;
            end
            S_I_WB: begin
                reg_write = 1'b1;
                retire    = 1'b1;
                state_d   = S_FETCH;
            end
            S_BRANCH: begin
                alu_src_a = 1'b1;
                alu_op    = ALU_SUB;
                pc_src    = PC_SRC_ALUOUT;
                pc_write  = (bus.opcode == OP_BEQ) ? bus.zero : !bus.zero;
                retire    = 1'b1;
                state_d   = S_FETCH;
            end
            S_JUMP: begin
                pc_src   = PC_SRC_JUMP;
                pc_write = 1'b1;
                retire   = 1'b1;
                state_d  = S_FETCH;
            end
            S_TRAP: illegal = 1'b1;
            default: state_d = S_IDLE;
        endcase
    end

    assign bus.mem_req    = mem_req;
    assign bus.mem_we     = mem_we;
    assign bus.iord       = iord;
    assign bus.ir_write   = ir_write;
    assign bus.pc_write   = pc_write;
    assign bus.pc_src     = pc_src;
    assign bus.reg_write  = reg_write;
    assign bus.reg_dst    = reg_dst;
    assign bus.mem_to_reg = mem_to_reg;
    assign bus.alu_src_a  = alu_src_a;
    assign bus.alu_src_b  = alu_src_b;
    assign bus.ext_zero   = ext_zero;
    assign bus.alu_op     = alu_op;
    assign bus.illegal    = illegal;
    assign bus.retired    = retired_q;

endmodule

// File: tb/tb_multicycle_controller.sv
// Directed bench for multicycle_controller: walks instruction classes through the FSM
// and compares outputs against hand-computed values.
module tb_multicycle_controller;
    import mips_ctrl_pkg::*;

    bit   clk   = 1'b0;
    logic rst_n = 1'b0;
    int   n_checks = 0;
    int   n_pass   = 0;
    logic [31:0] exp_ret = 32'd0;

    multicycle_controller_if bus ();

    multicycle_controller dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    // Inputs change and outputs are sampled 2-3 time units after each rising edge.
    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic set_in(input logic [5:0] op, input logic [5:0] fn,
                          input logic z, input logic mr);
        bus.opcode    = op;
        bus.funct     = fn;
        bus.zero      = z;
        bus.mem_ready = mr;
        #1;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        #1;
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        exp_ret = 32'd0;
    endtask

    // Returns the number of clock edges until the FSM is back in FETCH (51 on timeout).
    task automatic count_to_fetch(output int n);
        n = 0;
        do begin
            tick();
            n++;
        end while (dut.state_q != S_FETCH && n <= 50);
    endtask

    task automatic test_reset();
        set_in(6'h00, 6'h00, 1'b0, 1'b0);
        n_checks++; if (dut.state_q !== S_IDLE) $display("FAIL reset_state: got %0d expected %0d", dut.state_q, S_IDLE); else n_pass++;
        n_checks++; if (bus.mem_req !== 1'b0) $display("FAIL reset_mem_req: got %b expected 0", bus.mem_req); else n_pass++;
        n_checks++; if (bus.retired !== 32'd0) $display("FAIL reset_retired: got %0h expected 0", bus.retired); else n_pass++;
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        n_checks++; if (dut.state_q !== S_IDLE) $display("FAIL reset_hold_idle: got %0d expected %0d", dut.state_q, S_IDLE); else n_pass++;
    endtask

    task automatic test_add();
        set_in(OP_RTYPE, FN_ADD, 1'b0, 1'b1);
        n_checks++; if ({bus.mem_req, bus.pc_write, bus.reg_write, bus.alu_src_b, bus.alu_op} !== 9'd0)
            $display("FAIL idle_outputs: got %0h expected 0", {bus.mem_req, bus.pc_write, bus.reg_write, bus.alu_src_b, bus.alu_op}); else n_pass++;
        tick();
        n_checks++; if (dut.state_q !== S_FETCH) $display("FAIL add_fetch_state: got %0d expected %0d", dut.state_q, S_FETCH); else n_pass++;
        n_checks++; if ({bus.mem_req, bus.iord, bus.ir_write, bus.pc_write, bus.alu_src_a, bus.alu_src_b, bus.pc_src} !== 9'b1_0_1_1_0_01_00)
            $display("FAIL add_fetch_outs: got %b expected 101100100", {bus.mem_req, bus.iord, bus.ir_write, bus.pc_write, bus.alu_src_a, bus.alu_src_b, bus.pc_src}); else n_pass++;
        tick();
        n_checks++; if (bus.alu_src_b !== 2'b11 || dut.state_q !== S_DECODE) $display("FAIL add_decode: got src_b=%b state=%0d expected src_b=11 state=%0d", bus.alu_src_b, dut.state_q, S_DECODE); else n_pass++;
        tick();
        n_checks++; if (dut.state_q !== S_R_EXEC) $display("FAIL add_rexec_state: got %0d expected %0d", dut.state_q, S_R_EXEC); else n_pass++;
        n_checks++; if ({bus.alu_op, bus.alu_src_a, bus.alu_src_b} !== 7'b0000_1_00) $display("FAIL add_rexec_outs: got %b expected 0000100", {bus.alu_op, bus.alu_src_a, bus.alu_src_b}); else n_pass++;
        tick();
        n_checks++; if ({bus.reg_write, bus.reg_dst, bus.mem_to_reg} !== 3'b110) $display("FAIL add_rwb_outs: got %b expected 110", {bus.reg_write, bus.reg_dst, bus.mem_to_reg}); else n_pass++;
        n_checks++; if (bus.retired !== 32'd0) $display("FAIL add_retired_before: got %0d expected 0", bus.retired); else n_pass++;
        tick();
        exp_ret = 32'd1;
        n_checks++; if (dut.state_q !== S_FETCH) $display("FAIL add_back_fetch: got %0d expected %0d", dut.state_q, S_FETCH); else n_pass++;
        n_checks++; if (bus.retired !== exp_ret) $display("FAIL add_retired: got %0d expected %0d", bus.retired, exp_ret); else n_pass++;
    endtask

    task automatic test_lw_wait();
        state_t exp_st[9] = '{S_FETCH, S_FETCH, S_FETCH, S_DECODE, S_MEM_ADDR,
                              S_MEM_READ, S_MEM_READ, S_MEM_READ, S_MEM_WB};
        logic   exp_req[9] = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0};
        int     ir_pulses = 0;
        bus.opcode = OP_LW;
        for (int c = 0; c < 9; c++) begin
            bus.mem_ready = (c == 2 || c == 7);
            #1;
            if (bus.ir_write === 1'b1) ir_pulses++;
            n_checks++; if (dut.state_q !== exp_st[c]) $display("FAIL lw_state_c%0d: got %0d expected %0d", c, dut.state_q, exp_st[c]); else n_pass++;
            n_checks++; if (bus.mem_req !== exp_req[c]) $display("FAIL lw_mem_req_c%0d: got %b expected %b", c, bus.mem_req, exp_req[c]); else n_pass++;
            if (c >= 5 && c <= 7) begin
                n_checks++; if ({bus.iord, bus.mem_we} !== 2'b10) $display("FAIL lw_read_iord_c%0d: got %b expected 10", c, {bus.iord, bus.mem_we}); else n_pass++;
            end
            if (c == 8) begin
                n_checks++; if ({bus.reg_write, bus.mem_to_reg, bus.reg_dst} !== 3'b110) $display("FAIL lw_memwb_outs: got %b expected 110", {bus.reg_write, bus.mem_to_reg, bus.reg_dst}); else n_pass++;
            end
            tick();
        end
        exp_ret = exp_ret + 32'd1;
        n_checks++; if (ir_pulses !== 1) $display("FAIL lw_ir_pulses: got %0d expected 1", ir_pulses); else n_pass++;
        n_checks++; if (dut.state_q !== S_FETCH) $display("FAIL lw_back_fetch: got %0d expected %0d", dut.state_q, S_FETCH); else n_pass++;
        n_checks++; if (bus.retired !== exp_ret) $display("FAIL lw_retired: got %0d expected %0d", bus.retired, exp_ret); else n_pass++;
    endtask

    task automatic test_branch();
        set_in(OP_BEQ, 6'h00, 1'b1, 1'b1);
        tick(); tick();
        n_checks++; if (dut.state_q !== S_BRANCH) $display("FAIL beq_state: got %0d expected %0d", dut.state_q, S_BRANCH); else n_pass++;
        n_checks++; if ({bus.pc_write, bus.pc_src, bus.alu_op, bus.alu_src_a, bus.alu_src_b} !== 10'b1_01_0001_1_00)
            $display("FAIL beq_outs: got %b expected 1010001100", {bus.pc_write, bus.pc_src, bus.alu_op, bus.alu_src_a, bus.alu_src_b}); else n_pass++;
        tick();
        exp_ret = exp_ret + 32'd1;
        n_checks++; if (bus.retired !== exp_ret) $display("FAIL beq_retired: got %0d expected %0d", bus.retired, exp_ret); else n_pass++;
        set_in(OP_BNE, 6'h00, 1'b1, 1'b1);
        tick(); tick();
        n_checks++; if ({bus.pc_write, bus.pc_src} !== 3'b0_01) $display("FAIL bne_taken_z1: got %b expected 001", {bus.pc_write, bus.pc_src}); else n_pass++;
        bus.zero = 1'b0;
        #1;
        n_checks++; if (bus.pc_write !== 1'b1) $display("FAIL bne_z0_pc_write: got %b expected 1", bus.pc_write); else n_pass++;
        bus.zero = 1'b1;
        tick();
        exp_ret = exp_ret + 32'd1;
        n_checks++; if (dut.state_q !== S_FETCH || bus.retired !== exp_ret) $display("FAIL bne_retired: got %0d expected %0d", bus.retired, exp_ret); else n_pass++;
    endtask

    task automatic test_itype();
        set_in(OP_ORI, 6'h00, 1'b0, 1'b1);
        tick(); tick();
        n_checks++; if (dut.state_q !== S_I_EXEC) $display("FAIL ori_state: got %0d expected %0d", dut.state_q, S_I_EXEC); else n_pass++;
        n_checks++; if ({bus.ext_zero, bus.alu_op, bus.alu_src_a, bus.alu_src_b} !== 8'b1_0011_1_10)
            $display("FAIL ori_outs: got %b expected 10011110", {bus.ext_zero, bus.alu_op, bus.alu_src_a, bus.alu_src_b}); else n_pass++;
        tick();
        n_checks++; if ({bus.reg_write, bus.reg_dst, bus.mem_to_reg} !== 3'b100) $display("FAIL ori_iwb_outs: got %b expected 100", {bus.reg_write, bus.reg_dst, bus.mem_to_reg}); else n_pass++;
        tick();
        exp_ret = exp_ret + 32'd1;
        set_in(OP_LUI, 6'h00, 1'b0, 1'b1);
        tick(); tick();
        n_checks++; if ({bus.ext_zero, bus.alu_op} !== 5'b0_1000) $display("FAIL lui_outs: got %b expected 01000", {bus.ext_zero, bus.alu_op}); else n_pass++;
        tick(); tick();
        exp_ret = exp_ret + 32'd1;
        n_checks++; if (bus.retired !== exp_ret) $display("FAIL itype_retired: got %0d expected %0d", bus.retired, exp_ret); else n_pass++;
    endtask

    task automatic test_store_latency();
        int n;
        set_in(OP_SW, 6'h00, 1'b0, 1'b1);
        tick(); tick(); tick();
        n_checks++; if ({bus.mem_req, bus.mem_we, bus.iord, bus.reg_write} !== 4'b1110) $display("FAIL sw_outs: got %b expected 1110", {bus.mem_req, bus.mem_we, bus.iord, bus.reg_write}); else n_pass++;
        tick();
        exp_ret = exp_ret + 32'd1;
        n_checks++; if (bus.retired !== exp_ret) $display("FAIL sw_retired: got %0d expected %0d", bus.retired, exp_ret); else n_pass++;
        set_in(OP_RTYPE, FN_SUB, 1'b0, 1'b1);
        count_to_fetch(n);
        exp_ret = exp_ret + 32'd1;
        n_checks++; if (n !== 4) $display("FAIL sub_latency: got %0d expected 4", n); else n_pass++;
        set_in(OP_LW, 6'h00, 1'b0, 1'b1);
        count_to_fetch(n);
        exp_ret = exp_ret + 32'd1;
        n_checks++; if (n !== 5) $display("FAIL lw_latency: got %0d expected 5", n); else n_pass++;
        set_in(OP_BEQ, 6'h00, 1'b0, 1'b1);
        count_to_fetch(n);
        exp_ret = exp_ret + 32'd1;
        n_checks++; if (n !== 3) $display("FAIL beq_latency: got %0d expected 3", n); else n_pass++;
        n_checks++; if (bus.retired !== exp_ret) $display("FAIL latency_retired: got %0d expected %0d", bus.retired, exp_ret); else n_pass++;
    endtask

    task automatic test_trap();
        logic held = 1'b1;
        logic [31:0] ret_at_trap;
        set_in(6'h3F, 6'h00, 1'b0, 1'b1);
        tick(); tick();
        n_checks++; if (dut.state_q !== S_TRAP || bus.illegal !== 1'b1) $display("FAIL trap_enter: got state=%0d illegal=%b expected state=%0d illegal=1", dut.state_q, bus.illegal, S_TRAP); else n_pass++;
        ret_at_trap = exp_ret;
        for (int i = 0; i < 12; i++) begin
            tick();
            if (bus.illegal !== 1'b1 || bus.mem_req !== 1'b0 || bus.pc_write !== 1'b0 || bus.reg_write !== 1'b0) held = 1'b0;
        end
        n_checks++; if (held !== 1'b1) $display("FAIL trap_hold: got %b expected 1", held); else n_pass++;
        n_checks++; if (bus.retired !== ret_at_trap) $display("FAIL trap_retired: got %0d expected %0d", bus.retired, ret_at_trap); else n_pass++;
        do_reset();
        n_checks++; if (dut.state_q !== S_IDLE || bus.illegal !== 1'b0) $display("FAIL trap_reset: got state=%0d illegal=%b expected state=0 illegal=0", dut.state_q, bus.illegal); else n_pass++;
        set_in(OP_RTYPE, 6'h00, 1'b0, 1'b1);
        tick(); tick(); tick();
        n_checks++; if (dut.state_q !== S_TRAP) $display("FAIL rfunct0_trap: got %0d expected %0d", dut.state_q, S_TRAP); else n_pass++;
        tick(); tick();
        n_checks++; if (bus.illegal !== 1'b1 || bus.retired !== 32'd0) $display("FAIL rfunct0_hold: got illegal=%b retired=%0d expected 1 and 0", bus.illegal, bus.retired); else n_pass++;
        do_reset();
    endtask

    task automatic test_wrap_and_reset();
        force dut.retired_q = 32'hFFFF_FFFF;
        #1;
        release dut.retired_q;
        #1;
        n_checks++; if (bus.retired !== 32'hFFFF_FFFF) $display("FAIL wrap_preload: got %0h expected ffffffff", bus.retired); else n_pass++;
        tick();
        set_in(OP_J, 6'h00, 1'b0, 1'b1);
        tick(); tick();
        n_checks++; if ({bus.pc_write, bus.pc_src, bus.mem_req} !== 4'b1_10_0) $display("FAIL jump_outs: got %b expected 1100", {bus.pc_write, bus.pc_src, bus.mem_req}); else n_pass++;
        tick();
        n_checks++; if (bus.retired !== 32'd0) $display("FAIL wrap_retired: got %0h expected 0", bus.retired); else n_pass++;
        set_in(OP_RTYPE, FN_ADD, 1'b0, 1'b0);
        tick();
        n_checks++; if (dut.state_q !== S_FETCH || bus.mem_req !== 1'b1) $display("FAIL midfetch_wait: got state=%0d mem_req=%b expected %0d and 1", dut.state_q, bus.mem_req, S_FETCH); else n_pass++;
        rst_n = 1'b0;
        #1;
        n_checks++; if (bus.mem_req !== 1'b0) $display("FAIL midfetch_async_req: got %b expected 0", bus.mem_req); else n_pass++;
        n_checks++; if (dut.state_q !== S_IDLE) $display("FAIL midfetch_async_state: got %0d expected %0d", dut.state_q, S_IDLE); else n_pass++;
        @(negedge clk);
        rst_n = 1'b1;
        #1;
    endtask

    initial begin
        test_reset();
        test_add();
        test_lw_wait();
        test_branch();
        test_itype();
        test_store_latency();
        test_trap();
        test_wrap_and_reset();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation still running at %0t, expected completion", $time);
        $display("%0d/%0d checks passed", n_pass, n_checks + 1);
        $fatal(1, "watchdog expired");
    end

endmodule
